// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types and helpers for the byte-enable dual-port RAM with clear.
//   ram_clr_state_e : clear sequencer states
//   nbe()           : number of byte-enable lanes for a word width
//   read_latency()  : read latency in cycles for a given OUT_REG setting
// ---------------------------------------------------------------------------
package ram_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_READY
  } ram_clr_state_e;

  localparam int unsigned LAT_NO_OUT_REG = 1;
  localparam int unsigned LAT_OUT_REG    = 2;

  function automatic int unsigned nbe(input int unsigned width, input int unsigned byte_w);
    return width / byte_w;
  endfunction

  function automatic int unsigned read_latency(input int unsigned out_reg);
    return (out_reg != 0) ? LAT_OUT_REG : LAT_NO_OUT_REG;
  endfunction

endpackage

// File: rtl/ram_dp_be_core.sv
// ---------------------------------------------------------------------------
// ram_dp_be_core
// Behavioural true-dual-port array with per-lane write enables.
// A port reading the address it writes this cycle sees the merged new word;
// a port reading an address the other port writes sees the old word.
// No reset, no FSM.
// Ports (x = a, b):
//   clk        in  1        clock
//   i_we_x     in  1        write enable
//   i_be_x     in  NBE      byte lane enables
//   i_addr_x   in  WIDTHAD  word address
//   i_wdata_x  in  WIDTH    write data
//   i_re_x     in  1        read enable; o_q_x updates only when set
//   o_q_x      out WIDTH    registered read data
// ---------------------------------------------------------------------------
module ram_dp_be_core
  import ram_pkg::*;
#(
  parameter int unsigned WIDTHAD   = 10,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BYTE_W    = 8,
  parameter string       INIT_FILE = "UNUSED"
) (
  input  logic                           clk,
  input  logic                           i_we_a,
  input  logic [nbe(WIDTH, BYTE_W)-1:0]  i_be_a,
  input  logic [WIDTHAD-1:0]             i_addr_a,
  input  logic [WIDTH-1:0]               i_wdata_a,
  input  logic                           i_re_a,
  output logic [WIDTH-1:0]               o_q_a,
  input  logic                           i_we_b,
  input  logic [nbe(WIDTH, BYTE_W)-1:0]  i_be_b,
  input  logic [WIDTHAD-1:0]             i_addr_b,
  input  logic [WIDTH-1:0]               i_wdata_b,
  input  logic                           i_re_b,
  output logic [WIDTH-1:0]               o_q_b
);

  localparam int unsigned NBE   = nbe(WIDTH, BYTE_W);
  localparam int unsigned DEPTH = 1 << WIDTHAD;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_old_a, w_old_b;
  logic [WIDTH-1:0] w_new_a, w_new_b;

  assign w_old_a = r_mem[i_addr_a];
  assign w_old_b = r_mem[i_addr_b];

  // Merged word as it will look after this port's byte-enable update.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_new_a = w_old_a;
    w_new_b = w_old_b;
    for (int l = 0; l < NBE; l++) begin
      if (i_be_a[l]) w_new_a[l*BYTE_W +: BYTE_W] = i_wdata_a[l*BYTE_W +: BYTE_W];
      if (i_be_b[l]) w_new_b[l*BYTE_W +: BYTE_W] = i_wdata_b[l*BYTE_W +: BYTE_W];
    end
  end

  // Writes are per lane so that two ports hitting the same word on disjoint
  // lanes both land; lane priority between ports is resolved by the caller.
  // NOTE: the array has no reset; clearing it is a sequenced job done by the
  // owner, which keeps this mappable onto block RAM.
  // NOTE: state is updated with non-blocking assignments so reads in this
  // block see the pre-edge array contents (OLD_DATA across ports).
  always_ff @(posedge clk) begin
    for (int l = 0; l < NBE; l++) begin
      if (i_we_b && i_be_b[l]) r_mem[i_addr_b][l*BYTE_W +: BYTE_W] <= i_wdata_b[l*BYTE_W +: BYTE_W];
      if (i_we_a && i_be_a[l]) r_mem[i_addr_a][l*BYTE_W +: BYTE_W] <= i_wdata_a[l*BYTE_W +: BYTE_W];
    end
    if (i_re_a) o_q_a <= i_we_a ? w_new_a : w_old_a;
    if (i_re_b) o_q_b <= i_we_b ? w_new_b : w_old_b;
  end

endmodule

// File: rtl/ram_dp_be_clr.sv
// ---------------------------------------------------------------------------
// ram_dp_be_clr
// Single-clock true-dual-port RAM with byte enables, optional output register,
// per-port read-valid strobes and a clear-after-reset sequencer.
// Ports (x = a, b):
//   clk          in  1        clock
//   rst          in  1        synchronous active-high reset
//   busy         out 1        clear sequencer owns the array; requests dropped
//   address_x    in  WIDTHAD  word address
//   wren_x       in  1        write request
//   byteena_x    in  NBE      byte lane enables for writes
//   data_x       in  WIDTH    write data
//   rden_x       in  1        read request
//   q_x          out WIDTH    read data, holds between reads
//   q_valid_x    out 1        one-cycle strobe per accepted read
// ---------------------------------------------------------------------------
module ram_dp_be_clr
  import ram_pkg::*;
#(
  parameter int unsigned WIDTHAD        = 10,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter string       INIT_FILE      = "UNUSED"
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           busy,
  input  logic [WIDTHAD-1:0]             address_a,
  input  logic                           wren_a,
  input  logic [nbe(WIDTH, BYTE_W)-1:0]  byteena_a,
  input  logic [WIDTH-1:0]               data_a,
  input  logic                           rden_a,
  output logic [WIDTH-1:0]               q_a,
  output logic                           q_valid_a,
  input  logic [WIDTHAD-1:0]             address_b,
  input  logic                           wren_b,
  input  logic [nbe(WIDTH, BYTE_W)-1:0]  byteena_b,
  input  logic [WIDTH-1:0]               data_b,
  input  logic                           rden_b,
  output logic [WIDTH-1:0]               q_b,
  output logic                           q_valid_b
);

  localparam int unsigned NBE = nbe(WIDTH, BYTE_W);
  localparam logic [WIDTHAD-1:0] CNT_LAST = '1;

  if (WIDTH % BYTE_W != 0) begin : g_width_chk
    $error("ram_dp_be_clr: WIDTH must be a multiple of BYTE_W");
  end

  // ---------------- clear sequencer ----------------
  ram_clr_state_e     r_state, w_state_nxt;
  logic [WIDTHAD-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic               w_busy, w_clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    w_busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy      = (CLEAR_ON_RESET != 0);
        w_state_nxt = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      end
      S_CLEAR: begin
        w_busy   = 1'b1;
        w_clr_we = 1'b1;
        // The counter parks on the last word; only rst brings it back to 0.
        if (r_clr_cnt == CNT_LAST) w_state_nxt = S_READY;
        else                       w_clr_cnt_nxt = r_clr_cnt + 1'b1;
      end
      S_READY: ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = w_busy;

  // ---------------- request acceptance ----------------
  logic w_open;
  logic w_rd_a, w_rd_b, w_wr_a, w_wr_b;

  assign w_open = ~w_busy & ~rst;
  assign w_rd_a = rden_a & w_open;
  assign w_rd_b = rden_b & w_open;
  assign w_wr_a = wren_a & w_open;
  assign w_wr_b = wren_b & w_open;

  // Port A of the array is shared with the clear sequencer; the two never
  // overlap because user requests are refused while busy.
  logic                 w_core_we_a;
  logic [NBE-1:0]       w_core_be_a, w_core_be_b;
  logic [WIDTHAD-1:0]   w_core_addr_a;
  logic [WIDTH-1:0]     w_core_wdata_a;
  logic [WIDTH-1:0]     w_core_q_a, w_core_q_b;

  assign w_core_we_a    = w_clr_we | w_wr_a;
  assign w_core_be_a    = w_clr_we ? '1 : byteena_a;
  assign w_core_addr_a  = w_clr_we ? r_clr_cnt : address_a;
  assign w_core_wdata_a = w_clr_we ? '0 : data_a;

  // Dual write to one word: B only lands on lanes A leaves untouched.
  assign w_core_be_b = byteena_b &
                       ~((w_wr_a && w_wr_b && (address_a == address_b)) ? byteena_a : '0);

  ram_dp_be_core #(
    .WIDTHAD  (WIDTHAD),
    .WIDTH    (WIDTH),
    .BYTE_W   (BYTE_W),
    .INIT_FILE(INIT_FILE)
  ) u_core (
    .clk      (clk),
    .i_we_a   (w_core_we_a),
    .i_be_a   (w_core_be_a),
    .i_addr_a (w_core_addr_a),
    .i_wdata_a(w_core_wdata_a),
    .i_re_a   (w_rd_a),
    .o_q_a    (w_core_q_a),
    .i_we_b   (w_wr_b),
    .i_be_b   (w_core_be_b),
    .i_addr_b (address_b),
    .i_wdata_b(data_b),
    .i_re_b   (w_rd_b),
    .o_q_b    (w_core_q_b)
  );

  // ---------------- read-valid pipeline and output stage ----------------
  logic r_vld1_a, r_vld1_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld1_a <= 1'b0;
      r_vld1_b <= 1'b0;
    end else begin
      r_vld1_a <= w_rd_a;
      r_vld1_b <= w_rd_b;
    end
  end

  if (read_latency(OUT_REG) == LAT_OUT_REG) begin : g_out_reg
    logic [WIDTH-1:0] r_q2_a, r_q2_b;
    logic             r_vld2_a, r_vld2_b;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_q2_a   <= '0;
        r_q2_b   <= '0;
        r_vld2_a <= 1'b0;
        r_vld2_b <= 1'b0;
      end else begin
        r_vld2_a <= r_vld1_a;
        r_vld2_b <= r_vld1_b;
        if (r_vld1_a) r_q2_a <= w_core_q_a;
        if (r_vld1_b) r_q2_b <= w_core_q_b;
      end
    end

    assign q_a       = r_q2_a;
    assign q_b       = r_q2_b;
    assign q_valid_a = r_vld2_a;
    assign q_valid_b = r_vld2_b;
  end else begin : g_no_out_reg
    // The array output register has no reset, so q is forced to 0 until the
    // first read after reset has returned.
    logic r_seen_a, r_seen_b;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_seen_a <= 1'b0;
        r_seen_b <= 1'b0;
      end else begin
        if (r_vld1_a) r_seen_a <= 1'b1;
        if (r_vld1_b) r_seen_b <= 1'b1;
      end
    end

    assign q_a       = (r_seen_a | r_vld1_a) ? w_core_q_a : '0;
    assign q_b       = (r_seen_b | r_vld1_b) ? w_core_q_b : '0;
    assign q_valid_a = r_vld1_a;
    assign q_valid_b = r_vld1_b;
  end

endmodule

// File: tb/tb_ram_dp_be_clr.sv
// ---------------------------------------------------------------------------
// tb_ram_dp_be_clr
// Two instances share all stimulus: u_dut0 with OUT_REG=0, u_dut1 with
// OUT_REG=1. WIDTHAD=4, WIDTH=32, clear on reset enabled.
// ---------------------------------------------------------------------------
module tb_ram_dp_be_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  address_a, address_b;
  logic        wren_a, wren_b, rden_a, rden_b;
  logic [3:0]  byteena_a, byteena_b;
  logic [31:0] data_a, data_b;

  logic        busy0, busy1;
  logic [31:0] q0_a, q0_b, q1_a, q1_b;
  logic        qv0_a, qv0_b, qv1_a, qv1_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_dp_be_clr #(.WIDTHAD(4), .WIDTH(32), .BYTE_W(8), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .rst(rst), .busy(busy0),
    .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a),
    .rden_a(rden_a), .q_a(q0_a), .q_valid_a(qv0_a),
    .address_b(address_b), .wren_b(wren_b), .byteena_b(byteena_b), .data_b(data_b),
    .rden_b(rden_b), .q_b(q0_b), .q_valid_b(qv0_b)
  );

  ram_dp_be_clr #(.WIDTHAD(4), .WIDTH(32), .BYTE_W(8), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst), .busy(busy1),
    .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a),
    .rden_a(rden_a), .q_a(q1_a), .q_valid_a(qv1_a),
    .address_b(address_b), .wren_b(wren_b), .byteena_b(byteena_b), .data_b(data_b),
    .rden_b(rden_b), .q_b(q1_b), .q_valid_b(qv1_b)
  );

  typedef struct {
    string       name;
    logic        wr_a;
    logic [3:0]  be_a;
    logic [3:0]  ad_a;
    logic [31:0] d_a;
    logic        rd_a;
    logic        wr_b;
    logic [3:0]  be_b;
    logic [3:0]  ad_b;
    logic [31:0] d_b;
    logic        rd_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
    byteena_a = 4'h0; byteena_b = 4'h0;
  endtask

  function automatic vec_t mk(input string n,
                              input logic wa, input logic [3:0] ba, input logic [3:0] aa,
                              input logic [31:0] da, input logic ra,
                              input logic wb, input logic [3:0] bb, input logic [3:0] ab,
                              input logic [31:0] db, input logic rb,
                              input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.name = n;
    v.wr_a = wa; v.be_a = ba; v.ad_a = aa; v.d_a = da; v.rd_a = ra;
    v.wr_b = wb; v.be_b = bb; v.ad_b = ab; v.d_b = db; v.rd_b = rb;
    v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  // Counts cycles with busy high, starting in the cycle rst is released.
  task automatic busy_len(input string name);
    int n;
    logic saw_v;
    n = 0;
    saw_v = 1'b0;
    while (busy0 && n < 100) begin
      n++;
      if (qv0_a || qv0_b || qv1_a || qv1_b) saw_v = 1'b1;
      cyc();
    end
    idle();
    check({name, " busy cycles"}, n, 17);
    check({name, " no q_valid while busy"}, {31'd0, saw_v}, 0);
    check({name, " busy1 low"}, {31'd0, busy1}, 0);
  endtask

  initial begin
    rst = 1'b1;
    address_a = '0; address_b = '0; data_a = '0; data_b = '0;
    idle();

    vecs[0]  = mk("wr5 full",        1, 4'hF, 4'd5, 32'h11223344, 0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0, 32'h0);
    vecs[1]  = mk("wr5 be0101",      1, 4'h5, 4'd5, 32'hAABBCCDD, 0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0, 32'h0);
    vecs[2]  = mk("rdA 5",           0, 4'h0, 4'd5, 32'h0, 1, 0, 4'h0, 4'd0, 32'h0, 0, 32'h11BB33DD, 32'h0);
    vecs[3]  = mk("rdB 5",           0, 4'h0, 4'd0, 32'h0, 0, 0, 4'h0, 4'd5, 32'h0, 1, 32'h0, 32'h11BB33DD);
    vecs[4]  = mk("coll wrA rdAB 7", 1, 4'hF, 4'd7, 32'hFFFFFFFF, 1, 0, 4'h0, 4'd7, 32'h0, 1, 32'hFFFFFFFF, 32'h0);
    vecs[5]  = mk("rdA 7",           0, 4'h0, 4'd7, 32'h0, 1, 0, 4'h0, 4'd0, 32'h0, 0, 32'hFFFFFFFF, 32'h0);
    vecs[6]  = mk("dual wr 9",       1, 4'h1, 4'd9, 32'h000000AA, 0, 1, 4'h3, 4'd9, 32'h0000BBBB, 0, 32'h0, 32'h0);
    vecs[7]  = mk("rdB 9",           0, 4'h0, 4'd0, 32'h0, 0, 0, 4'h0, 4'd9, 32'h0, 1, 32'h0, 32'h0000BBAA);
    vecs[8]  = mk("B wr+rd 2 newd",  1, 4'h0, 4'd2, 32'h12345678, 0, 1, 4'hC, 4'd2, 32'hCAFEF00D, 1, 32'h0, 32'hCAFE0000);
    vecs[9]  = mk("rdA 2",           0, 4'h0, 4'd2, 32'h0, 1, 0, 4'h0, 4'd0, 32'h0, 0, 32'hCAFE0000, 32'h0);
    vecs[10] = mk("wrB 12",          0, 4'h0, 4'd0, 32'h0, 0, 1, 4'hF, 4'd12, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    vecs[11] = mk("rdA 12 rdB 15",   0, 4'h0, 4'd12, 32'h0, 1, 0, 4'h0, 4'd15, 32'h0, 1, 32'hDEADBEEF, 32'h0);
    vecs[12] = mk("dual full 9 rdA", 1, 4'hF, 4'd9, 32'h01020304, 1, 1, 4'hF, 4'd9, 32'h05060708, 0, 32'h01020304, 32'h0);
    vecs[13] = mk("rdB 9 A wins",    0, 4'h0, 4'd0, 32'h0, 0, 0, 4'h0, 4'd9, 32'h0, 1, 32'h0, 32'h01020304);

    // ---- reset state and clear after reset, requests during busy dropped ----
    repeat (3) cyc();
    check("reset busy0", {31'd0, busy0}, 1);
    check("reset busy1", {31'd0, busy1}, 1);
    check("reset q0_a", q0_a, 0);
    check("reset q1_b", q1_b, 0);
    check("reset qv0_a", {31'd0, qv0_a}, 0);
    rst = 1'b0;
    rden_a = 1'b1; address_a = 4'd3;
    wren_b = 1'b1; byteena_b = 4'hF; address_b = 4'd0; data_b = 32'h55555555; rden_b = 1'b1;
    busy_len("clear1");

    // ---- whole array reads zero, streamed one word per cycle on both ports ----
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        rden_a = 1'b1; address_a = 4'(i);
        rden_b = 1'b1; address_b = 4'(15 - i);
      end else begin
        idle();
      end
      cyc();
      if (i < 16) begin
        check($sformatf("clr qv0_a %0d", i), {31'd0, qv0_a}, 1);
        check($sformatf("clr q0_a %0d", i), q0_a, 0);
        check($sformatf("clr q0_b %0d", 15 - i), q0_b, 0);
      end
      if (i > 0) begin
        check($sformatf("clr qv1_b %0d", i), {31'd0, qv1_b}, 1);
        check($sformatf("clr q1_a %0d", i - 1), q1_a, 0);
      end
    end

    // ---- table-driven single transactions ----
    for (int i = 0; i < NV; i++) begin
      wren_a = vecs[i].wr_a; byteena_a = vecs[i].be_a; address_a = vecs[i].ad_a;
      data_a = vecs[i].d_a;  rden_a = vecs[i].rd_a;
      wren_b = vecs[i].wr_b; byteena_b = vecs[i].be_b; address_b = vecs[i].ad_b;
      data_b = vecs[i].d_b;  rden_b = vecs[i].rd_b;
      cyc();
      idle();
      check({vecs[i].name, " qv0_a N+1"}, {31'd0, qv0_a}, {31'd0, vecs[i].rd_a});
      check({vecs[i].name, " qv0_b N+1"}, {31'd0, qv0_b}, {31'd0, vecs[i].rd_b});
      if (vecs[i].rd_a) check({vecs[i].name, " q0_a"}, q0_a, vecs[i].exp_a);
      if (vecs[i].rd_b) check({vecs[i].name, " q0_b"}, q0_b, vecs[i].exp_b);
      check({vecs[i].name, " qv1 early"}, {30'd0, qv1_a, qv1_b}, 0);
      cyc();
      check({vecs[i].name, " qv0 one-shot"}, {30'd0, qv0_a, qv0_b}, 0);
      if (vecs[i].rd_a) check({vecs[i].name, " q0_a hold"}, q0_a, vecs[i].exp_a);
      check({vecs[i].name, " qv1_a N+2"}, {31'd0, qv1_a}, {31'd0, vecs[i].rd_a});
      check({vecs[i].name, " qv1_b N+2"}, {31'd0, qv1_b}, {31'd0, vecs[i].rd_b});
      if (vecs[i].rd_a) check({vecs[i].name, " q1_a"}, q1_a, vecs[i].exp_a);
      if (vecs[i].rd_b) check({vecs[i].name, " q1_b"}, q1_b, vecs[i].exp_b);
      cyc();
      check({vecs[i].name, " qv1 one-shot"}, {30'd0, qv1_a, qv1_b}, 0);
    end

    // ---- back-to-back reads with distinct data ----
    rden_a = 1'b1; address_a = 4'd5;
    cyc();
    check("stream q0_a 5", q0_a, 32'h11BB33DD);
    address_a = 4'd7;
    cyc();
    idle();
    check("stream q0_a 7", q0_a, 32'hFFFFFFFF);
    check("stream qv0_a 7", {31'd0, qv0_a}, 1);
    check("stream q1_a 5", q1_a, 32'h11BB33DD);
    cyc();
    check("stream q1_a 7", q1_a, 32'hFFFFFFFF);
    check("stream qv1_a 7", {31'd0, qv1_a}, 1);
    check("stream qv0_a end", {31'd0, qv0_a}, 0);

    // ---- reset in the middle of a clear ----
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (7) cyc();
    check("midclear busy0", {31'd0, busy0}, 1);
    rst = 1'b1;
    cyc();
    check("re-reset busy0", {31'd0, busy0}, 1);
    check("re-reset q0_a", q0_a, 0);
    check("re-reset q1_a", q1_a, 0);
    rst = 1'b0;
    busy_len("clear2");
    rden_a = 1'b1; address_a = 4'd12;
    rden_b = 1'b1; address_b = 4'd9;
    cyc();
    idle();
    check("after clear2 q0_a 12", q0_a, 0);
    check("after clear2 q0_b 9", q0_b, 0);
    check("after clear2 qv0_a", {31'd0, qv0_a}, 1);
    cyc();
    check("after clear2 q1_a 12", q1_a, 0);
    check("after clear2 qv1_b", {31'd0, qv1_b}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
